// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the ALU decoder side and the registered ALU.
// The decoder side drives operands and the opcode; the ALU drives the registered result and zero flag.
interface alu_if;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero_flag;

    modport master (
        output in1,
        output in2,
        output alu_control,
        input  alu_result,
        input  zero_flag
    );

    modport slave (
        input  in1,
        input  in2,
        input  alu_control,
        output alu_result,
        output zero_flag
    );
endinterface

// File: rtl/alu.sv
// Registered 32-bit RV32 execute-stage ALU: combinational compute, one register stage, zero flag for branches.
// Optional multiply codes (MUL/MULH/MULHU) are built only when ALU_MULT_EN is defined; otherwise they read as reserved.
module alu (
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SLL   = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SRA   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_SUB   = 4'b1000,
        OP_SLTU  = 4'b1001,
        OP_PASSB = 4'b1010,
        OP_MUL   = 4'b1011,
        OP_MULH  = 4'b1100,
        OP_MULHU = 4'b1101
    } alu_op_e;

    logic [4:0]  shamt;
    logic [31:0] next_result;
    logic        next_zero;
    logic [31:0] alu_result_q;
    logic        zero_flag_q;

    assign shamt = bus.in2[4:0];

`ifdef ALU_MULT_EN
    logic [63:0] prod_uu;
    logic [31:0] prod_su_hi;

    // One unsigned multiplier serves all three codes; the signed high word
    // is recovered by subtracting each operand where the other is negative.
    assign prod_uu    = {32'd0, bus.in1} * {32'd0, bus.in2};
    assign prod_su_hi = prod_uu[63:32]
                      - (bus.in1[31] ? bus.in2 : 32'd0)
                      - (bus.in2[31] ? bus.in1 : 32'd0);
`endif

    always_comb begin
        next_result = 32'd0;
        case (bus.alu_control)
            OP_AND:   next_result = bus.in1 & bus.in2;
            OP_OR:    next_result = bus.in1 | bus.in2;
            OP_ADD:   next_result = bus.in1 + bus.in2;
            OP_SLL:   next_result = bus.in1 << shamt;
            OP_XOR:   next_result = bus.in1 ^ bus.in2;
            OP_SRL:   next_result = bus.in1 >> shamt;
            OP_SRA:   next_result = $unsigned($signed(bus.in1) >>> shamt);
            OP_SLT:   next_result = {31'd0, $signed(bus.in1) < $signed(bus.in2)};
            OP_SUB:   next_result = bus.in1 - bus.in2;
            OP_SLTU:  next_result = {31'd0, bus.in1 < bus.in2};
            OP_PASSB: next_result = bus.in2;
`ifdef ALU_MULT_EN
            OP_MUL:   next_result = prod_uu[31:0];
            OP_MULH:  next_result = prod_su_hi;
            OP_MULHU: next_result = prod_uu[63:32];
`endif
            default:  next_result = 32'd0;
        endcase
        next_zero = (next_result == 32'd0);
    end

    // The zero flag is taken from the same value that is registered so the pair never disagrees.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q <= 32'd0;
            zero_flag_q  <= 1'b1;
        end else begin
            alu_result_q <= next_result;
            zero_flag_q  <= next_zero;
        end
    end

    assign bus.alu_result = alu_result_q;
    assign bus.zero_flag  = zero_flag_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the registered ALU: expectations are queued when an operation is driven
// and popped when its registered result is due one edge later.
module tb_alu;

    logic clk;
    logic rst;
    alu_if bus ();

    int checks;
    int failures;

    logic [32:0] sb_q [$];
    string       name_q [$];

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded bound");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                            input logic [31:0] res, input logic zf, input string nm);
        bus.in1         = a;
        bus.in2         = b;
        bus.alu_control = c;
        sb_q.push_back({zf, res});
        name_q.push_back(nm);
    endtask

    task automatic test_reset();
        logic [32:0] e;
        string       nm;
        @(negedge clk);
        rst = 1'b1;
        drive_op(32'd23, 32'd42, 4'b0010, 32'd0, 1'b1, "reset");
        @(posedge clk); #1;
        e = sb_q.pop_front(); nm = name_q.pop_front();
        checks++;
        if (bus.alu_result !== e[31:0] || bus.zero_flag !== e[32]) begin
            failures++;
            $display("[TB] FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                     nm, bus.alu_result, bus.zero_flag, e[31:0], e[32]);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_op(32'd23, 32'd42, 4'b0010, 32'd65, 1'b0, "post_reset_add");
        @(posedge clk); #1;
        e = sb_q.pop_front(); nm = name_q.pop_front();
        checks++;
        if (bus.alu_result !== e[31:0] || bus.zero_flag !== e[32]) begin
            failures++;
            $display("[TB] FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                     nm, bus.alu_result, bus.zero_flag, e[31:0], e[32]);
        end
    endtask

    task automatic test_logic_arith();
        logic [31:0] a [9] = '{32'd23, 32'd23, 32'd23, 32'd42, 32'd23, 32'd23, 32'd42, 32'd42, 32'hFFFFFFFF};
        logic [31:0] b [9] = '{32'd42, 32'd42, 32'd42, 32'd23, 32'd42, 32'd42, 32'd23, 32'd42, 32'd1};
        logic [3:0]  c [9] = '{4'b0000, 4'b0001, 4'b0100, 4'b0100, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b0010};
        logic [31:0] r [9] = '{32'd2, 32'd63, 32'd61, 32'd61, 32'd65, 32'hFFFFFFED, 32'd19, 32'd0, 32'd0};
        logic        z [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        string       n [9] = '{"and", "or", "xor", "xor_swapped", "add", "sub_neg", "sub_pos", "sub_equal", "add_wrap"};
        logic [32:0] e;
        string       nm;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive_op(a[i], b[i], c[i], r[i], z[i], n[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (bus.alu_result !== e[31:0] || bus.zero_flag !== e[32]) begin
                failures++;
                $display("[TB] FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                         nm, bus.alu_result, bus.zero_flag, e[31:0], e[32]);
            end
        end
    endtask

    task automatic test_shift_compare();
        logic [31:0] a [8] = '{32'd1, 32'h80000000, 32'h80000000, 32'd1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [31:0] b [8] = '{32'd31, 32'd4, 32'd4, 32'd33, 32'd33, 32'd1, 32'd1, 32'd36};
        logic [3:0]  c [8] = '{4'b0011, 4'b0101, 4'b0110, 4'b0011, 4'b0110, 4'b0111, 4'b1001, 4'b0110};
        logic [31:0] r [8] = '{32'h80000000, 32'h08000000, 32'hF8000000, 32'd2, 32'hC0000000, 32'd1, 32'd0, 32'h07FFFFFF};
        logic        z [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        string       n [8] = '{"sll31", "srl4", "sra4", "sll_amt33", "sra_amt33", "slt", "sltu", "sra_pos_amt36"};
        logic [32:0] e;
        string       nm;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_op(a[i], b[i], c[i], r[i], z[i], n[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (bus.alu_result !== e[31:0] || bus.zero_flag !== e[32]) begin
                failures++;
                $display("[TB] FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                         nm, bus.alu_result, bus.zero_flag, e[31:0], e[32]);
            end
        end
    endtask

    task automatic test_passb_reserved_mult();
`ifdef ALU_MULT_EN
        logic [31:0] rm [3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
        logic        zm [3] = '{1'b0, 1'b0, 1'b0};
`else
        logic [31:0] rm [3] = '{32'd0, 32'd0, 32'd0};
        logic        zm [3] = '{1'b1, 1'b1, 1'b1};
`endif
        logic [31:0] a [6] = '{32'd99, 32'd23, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b [6] = '{32'h12345000, 32'd42, 32'd7, 32'd2, 32'd2, 32'd2};
        logic [3:0]  c [6] = '{4'b1010, 4'b1111, 4'b1110, 4'b1011, 4'b1100, 4'b1101};
        logic [31:0] r [6] = '{32'h12345000, 32'd0, 32'd0, rm[0], rm[1], rm[2]};
        logic        z [6] = '{1'b0, 1'b1, 1'b1, zm[0], zm[1], zm[2]};
        string       n [6] = '{"passb", "reserved_1111", "reserved_1110", "mul", "mulh", "mulhu"};
        logic [32:0] e;
        string       nm;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_op(a[i], b[i], c[i], r[i], z[i], n[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (bus.alu_result !== e[31:0] || bus.zero_flag !== e[32]) begin
                failures++;
                $display("[TB] FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                         nm, bus.alu_result, bus.zero_flag, e[31:0], e[32]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [6] = '{32'd10, 32'd10, 32'd7, 32'hF0F0F0F0, 32'd3, 32'h40000000};
        logic [31:0] b [6] = '{32'd20, 32'd10, 32'd9, 32'h0F0F0F0F, 32'd2, 32'd2};
        logic [3:0]  c [6] = '{4'b0010, 4'b1000, 4'b1001, 4'b0001, 4'b0111, 4'b0011};
        logic [31:0] r [6] = '{32'd30, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic        z [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        string       n [6] = '{"b2b_add", "b2b_sub_zero", "b2b_sltu", "b2b_or", "b2b_slt_false", "b2b_sll_out"};
        logic [32:0] e;
        string       nm;
        @(negedge clk);
        drive_op(a[0], b[0], c[0], r[0], z[0], n[0]);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i + 1 < 6) drive_op(a[i+1], b[i+1], c[i+1], r[i+1], z[i+1], n[i+1]);
            e = sb_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (bus.alu_result !== e[31:0] || bus.zero_flag !== e[32]) begin
                failures++;
                $display("[TB] FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                         nm, bus.alu_result, bus.zero_flag, e[31:0], e[32]);
            end
        end
    endtask

    task automatic test_hold();
        logic [32:0] e;
        string       nm;
        @(negedge clk);
        drive_op(32'd100, 32'd1, 4'b1000, 32'd99, 1'b0, "hold_sub");
        @(posedge clk); #1;
        e = sb_q.pop_front(); nm = name_q.pop_front();
        bus.in1 = 32'd0;
        bus.in2 = 32'd0;
        bus.alu_control = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.alu_result !== e[31:0] || bus.zero_flag !== e[32]) begin
            failures++;
            $display("[TB] FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                     nm, bus.alu_result, bus.zero_flag, e[31:0], e[32]);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.in1         = 32'd0;
        bus.in2         = 32'd0;
        bus.alu_control = 4'b0000;
        test_reset();
        test_logic_arith();
        test_shift_compare();
        test_passb_reserved_mult();
        test_back_to_back();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
